// File: rtl/issue_dispatch_nw.sv
// In-order issue queue feeding up to WIDTH execute slots per cycle, with
// intra-group hazard rules and a countdown scoreboard for late results.

module issue_dispatch_nw_lane (
  input  logic        first,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic        solo,
  input  logic        solo0,
  input  logic        br,
  input  logic        prior_br,
  input  logic [31:0] prior_wr,
  input  logic [31:0] busy,
  output logic        ok
);
  // prior_wr is a mask of rds written by older entries of this group.
  assign ok = !busy[rs1] && !busy[rs2] &&
              (first || (!solo0 && !solo && !(br && prior_br) &&
                         !prior_wr[rs1] && !prior_wr[rs2]));
endmodule

module issue_dispatch_nw #(
  parameter int WIDTH  = 2,
  parameter int DEPTH  = 8,
  parameter int PW     = 64,
  parameter int LD_LAT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         ex_stall,
  input  logic [WIDTH-1:0]             in_valid,
  output logic                         in_ready,
  input  logic [5*WIDTH-1:0]           in_rd,
  input  logic [5*WIDTH-1:0]           in_rs1,
  input  logic [5*WIDTH-1:0]           in_rs2,
  input  logic [WIDTH-1:0]             in_we,
  input  logic [WIDTH-1:0]             in_br,
  input  logic [WIDTH-1:0]             in_solo,
  input  logic [WIDTH-1:0]             in_long,
  input  logic [PW*WIDTH-1:0]          in_payload,
  output logic [WIDTH-1:0]             out_valid,
  output logic [PW*WIDTH-1:0]          out_payload,
  output logic [$clog2(WIDTH+1)-1:0]   out_num,
  output logic [$clog2(DEPTH+1)-1:0]   q_count
);
  localparam int AW   = $clog2(DEPTH);
  localparam int PTRW = AW + 1;
  localparam int NW   = $clog2(WIDTH+1);
  localparam int QW   = $clog2(DEPTH+1);
  localparam int CW   = $clog2(LD_LAT+1);

  typedef struct packed {
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic          we;
    logic          br;
    logic          solo;
    logic          lng;
    logic [PW-1:0] payload;
  } entry_t;

  entry_t                  mem [DEPTH];
  entry_t [WIDTH-1:0]      head, in_ent;
  logic [PTRW-1:0]         wr_ptr, rd_ptr, count;
  logic [31:0][CW-1:0]     cnt, cnt_nxt;
  logic [31:0]             busy;
  logic [WIDTH-1:0]        exists, lane_ok, prior_br;
  logic [WIDTH-1:0][31:0]  prior_wr;
  logic [NW-1:0]           enq_num;
  logic                    enq;

  assign count    = wr_ptr - rd_ptr;
  assign q_count  = QW'(count);
  // No credit for a same-cycle dequeue: readiness looks at occupancy only.
  assign in_ready = count <= PTRW'(DEPTH - WIDTH);

  always_comb begin
    enq_num = '0;
    for (int i = 0; i < WIDTH; i++) begin
      enq_num = enq_num + NW'(in_valid[i]);
      in_ent[i].rd      = in_rd[5*i +: 5];
      in_ent[i].rs1     = in_rs1[5*i +: 5];
      in_ent[i].rs2     = in_rs2[5*i +: 5];
      in_ent[i].we      = in_we[i];
      in_ent[i].br      = in_br[i];
      in_ent[i].solo    = in_solo[i];
      in_ent[i].lng     = in_long[i];
      in_ent[i].payload = in_payload[PW*i +: PW];
    end
  end
  assign enq = (|in_valid) && in_ready && !flush && !rst;

  always_comb begin
    for (int r = 0; r < 32; r++) busy[r] = cnt[r] != '0;
  end

  always_comb begin
    logic [31:0] wm;
    logic        bm;
    wm = '0;
    bm = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      head[k]     = mem[AW'(rd_ptr[AW-1:0] + AW'(k))];
      exists[k]   = count > PTRW'(k);
      prior_wr[k] = wm;
      prior_br[k] = bm;
      if (head[k].we && head[k].rd != 5'd0) wm[head[k].rd] = 1'b1;
      bm = bm | head[k].br;
    end
  end

  for (genvar k = 0; k < WIDTH; k++) begin : g_lane
    issue_dispatch_nw_lane u_lane (
      .first    (k == 0),
      .rs1      (head[k].rs1),
      .rs2      (head[k].rs2),
      .solo     (head[k].solo),
      .solo0    (head[0].solo),
      .br       (head[k].br),
      .prior_br (prior_br[k]),
      .prior_wr (prior_wr[k]),
      .busy     (busy),
      .ok       (lane_ok[k])
    );
  end

  // Issue chain stops at the first entry that cannot go.
  always_comb begin
    logic go;
    go          = !ex_stall && !flush && !rst;
    out_num     = '0;
    out_payload = '0;
    for (int k = 0; k < WIDTH; k++) begin
      go           = go && exists[k] && lane_ok[k];
      out_valid[k] = go;
      if (go) out_payload[PW*k +: PW] = head[k].payload;
      out_num      = out_num + NW'(go);
    end
  end

  // Younger issuing writers are applied last so they win on equal rd.
  always_comb begin
    for (int r = 0; r < 32; r++)
      cnt_nxt[r] = (cnt[r] == '0) ? '0 : cnt[r] - CW'(1);
    for (int k = 0; k < WIDTH; k++)
      if (out_valid[k] && head[k].lng && head[k].we && head[k].rd != 5'd0)
        cnt_nxt[head[k].rd] = CW'(LD_LAT);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTRW'(out_num);
      cnt    <= cnt_nxt;
      if (enq) wr_ptr <= wr_ptr + PTRW'(enq_num);
    end
  end

  always_ff @(posedge clk) begin
    if (enq)
      for (int i = 0; i < WIDTH; i++)
        if (in_valid[i]) mem[AW'(wr_ptr[AW-1:0] + AW'(i))] <= in_ent[i];
  end
endmodule
